oai_gw_pipe: RTL and testbench
==============================

OAI_GW_PIPE -- requirements
Module: oai_gw_pipe

Interface
REQ-001 SHALL provide parameter G, default 3, number of OR/AND groups (range 2..8).
REQ-002 SHALL provide parameter W, default 2, inputs per group (range 2..4).
REQ-003 SHALL provide parameter STAGES, default 2, pipeline depth in cycles (range 1..4).
REQ-004 SHALL provide parameter CW, default 16, toggle-counter width (range 4..32).
REQ-005 SHALL have port CK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-007 SHALL have port IN_VALID  input  1  A/MODE sample qualifier.
REQ-008 SHALL have port MODE  input  2  function select, sampled with A.
REQ-009 SHALL have port A  input  G*W  operands; group g = A[g*W +: W].
REQ-010 SHALL have port CNT_CLR  input  1  synchronous toggle-counter clear.
REQ-011 SHALL have port OUT_VALID  output  1  ZN updated this cycle.
REQ-012 SHALL have port ZN  output  1  registered result, held between valids.
REQ-013 SHALL have port TOGGLE_CNT  output  CW  count of ZN value changes.
REQ-014 SHALL have port CNT_SAT  output  1  TOGGLE_CNT at all-ones.

Function
REQ-015 SHALL compute, per MODE: 00 OAI: ZN = ~AND_g(OR(group g)); 01 OA: non-inverted OAI; 10 AOI: ZN = ~OR_g(AND(group g)); 11 AO: non-inverted AOI.
REQ-016 SHALL carry MODE alongside its A sample through the pipeline; a MODE change never affects in-flight samples.
REQ-017 SHALL have latency exactly STAGES cycles from IN_VALID high at edge N to OUT_VALID high after edge N+STAGES-1 (visible for one cycle).
REQ-018 SHALL accept one sample per cycle, no backpressure, no bubbles inserted; OUT_VALID pattern equals IN_VALID pattern delayed by STAGES.
REQ-019 STAGES=1: group reduction and final gate combinational into the single ZN register.
REQ-020 STAGES>=2: stage 1 registers G group terms (OR for modes 00/01, AND for 10/11) plus mode; stage 2 registers final result; stages 3..STAGES are pure valid/data delay.
REQ-021 Invalid pipeline slots SHALL not update ZN; ZN holds last valid result.
REQ-022 TOGGLE_CNT SHALL increment by 1 on each cycle where ZN loads a value differing from its previous value.
REQ-023 TOGGLE_CNT SHALL saturate at 2^CW-1; CNT_SAT high while saturated, further toggles ignored.
REQ-024 CNT_CLR SHALL set TOGGLE_CNT to 0 on the next edge; CNT_CLR coincident with a toggle yields 0 (clear wins).
REQ-025 Equal consecutive results SHALL assert OUT_VALID without incrementing TOGGLE_CNT.

Reset
REQ-026 RST SHALL asynchronously force ZN=1, OUT_VALID=0, TOGGLE_CNT=0, CNT_SAT=0, all pipeline valid bits 0, all stage data 0.
REQ-027 RST asserted mid-operation SHALL discard all in-flight samples; no OUT_VALID for them after release.
REQ-028 First valid result after reset SHALL compare against ZN=1 for toggle counting.

Structure
REQ-029 Mode encodings (OAI/OA/AOI/AO) and parameter range limits SHALL live in shared package oai_gw_pkg.
REQ-030 Per-group reduction SHALL be sub-module oai_gw_group (W-input OR/AND selectable by mode bit 1), instantiated G times.
REQ-031 Out-of-range parameters SHALL fail elaboration.

Verification (G=3, W=2, STAGES=2, CW=16 unless stated)
REQ-032 Reset: RST=1 -> ZN=1, OUT_VALID=0, TOGGLE_CNT=0, CNT_SAT=0 without clock edge.
REQ-033 OAI: A=6'b10_10_01, MODE=00, one-cycle IN_VALID -> OUT_VALID 2 cycles later, ZN=0, TOGGLE_CNT=1; then A=6'b00_10_01 -> ZN=1, TOGGLE_CNT=2.
REQ-034 Modes: A=6'b11_11_11 back-to-back MODE=10,11,00,01 -> ZN=0,1,0,1 on four consecutive OUT_VALID cycles.
REQ-035 Throughput/hold: 8 back-to-back samples alternating ZN, then 5 idle cycles -> 8 consecutive OUT_VALID, TOGGLE_CNT=8, ZN stable during idle.
REQ-036 Saturation: CW=4, 20 alternating results -> TOGGLE_CNT=15, CNT_SAT=1; CNT_CLR with a toggle in the same cycle -> TOGGLE_CNT=0, CNT_SAT=0.
REQ-037 Mid-pipe reset: STAGES=4, 3 samples in flight, RST pulse -> no OUT_VALID for those samples, ZN=1.

Source files
------------

// File: rtl/oai_gw_pkg.sv
// Shared definitions for the OAI/AOI gate pipeline: function-select
// encodings, legal parameter ranges and small mode-decoding helpers.
package oai_gw_pkg;

  // Function select carried with every sample
  typedef enum logic [1:0] {
    MODE_OAI = 2'b00,  // ~AND of group ORs
    MODE_OA  = 2'b01,  //  AND of group ORs
    MODE_AOI = 2'b10,  // ~OR of group ANDs
    MODE_AO  = 2'b11   //  OR of group ANDs
  } mode_e;

  // Legal parameter ranges
  localparam int G_MIN      = 2;
  localparam int G_MAX      = 8;
  localparam int W_MIN      = 2;
  localparam int W_MAX      = 4;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int CW_MIN     = 4;
  localparam int CW_MAX     = 32;

  // Group terms are ANDs for the AOI family, ORs for the OAI family
  function automatic logic group_uses_and(input logic [1:0] m);
    return (mode_e'(m) == MODE_AOI) || (mode_e'(m) == MODE_AO);
  endfunction

endpackage

// File: rtl/oai_gw_group.sv
// One W-input group reduction: OR of the inputs, or AND of the inputs when
// the AOI/AO family is selected.
module oai_gw_group #(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic         sel_and_i,
  output logic         term_o
);

  // Pick the reduction for this group
  always_comb begin
    term_o = sel_and_i ? (&a_i) : (|a_i);
  end

endmodule

// File: rtl/oai_gw_pipe.sv
// Pipelined configurable OAI/OA/AOI/AO gate with a saturating counter of
// output value changes. Mode travels with each sample, so mode changes on
// the input never disturb samples already in flight.
module oai_gw_pipe
  import oai_gw_pkg::*;
#(
  parameter int G      = 3,
  parameter int W      = 2,
  parameter int STAGES = 2,
  parameter int CW     = 16
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            IN_VALID,
  input  logic [1:0]      MODE,
  input  logic [G*W-1:0]  A,
  input  logic            CNT_CLR,
  output logic            OUT_VALID,
  output logic            ZN,
  output logic [CW-1:0]   TOGGLE_CNT,
  output logic            CNT_SAT
);

  // Refuse to build with parameters outside the supported envelope
  if (G < G_MIN || G > G_MAX) begin : g_bad_g
    $error("oai_gw_pipe: G out of range");
  end
  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("oai_gw_pipe: W out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("oai_gw_pipe: STAGES out of range");
  end
  if (CW < CW_MIN || CW > CW_MAX) begin : g_bad_cw
    $error("oai_gw_pipe: CW out of range");
  end

  // Final gate over the G group terms for a given mode
  function automatic logic final_gate(input logic [G-1:0] t, input logic [1:0] m);
    logic r;
    r = 1'b1;
    case (mode_e'(m))
      MODE_OAI: r = ~(&t);
      MODE_OA:  r = &t;
      MODE_AOI: r = ~(|t);
      MODE_AO:  r = |t;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

  // Group reductions on the live input sample
  logic [G-1:0] terms;
  logic         sel_and;

  assign sel_and = group_uses_and(MODE);

  genvar gi;
  for (gi = 0; gi < G; gi++) begin : g_grp
    oai_gw_group #(.W(W)) u_grp (
      .a_i       (A[gi*W +: W]),
      .sel_and_i (sel_and),
      .term_o    (terms[gi])
    );
  end

  // Valid/result pair presented to the output register
  logic load_v;
  logic load_r;

  if (STAGES == 1) begin : g_comb
    // Whole function collapses into the output register
    assign load_v = IN_VALID;
    assign load_r = final_gate(terms, MODE);
  end else begin : g_pipe
    logic         s1_v_q;
    logic [G-1:0] s1_t_q;
    logic [1:0]   s1_m_q;
    logic         res2;

    // Stage 1: capture group terms together with their mode
    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        s1_v_q <= 1'b0;
        s1_t_q <= '0;
        s1_m_q <= 2'b00;
      end else begin
        s1_v_q <= IN_VALID;
        if (IN_VALID) begin
          s1_t_q <= terms;
          s1_m_q <= MODE;
        end
      end
    end

    assign res2 = final_gate(s1_t_q, s1_m_q);

    if (STAGES == 2) begin : g_direct
      assign load_v = s1_v_q;
      assign load_r = res2;
    end else begin : g_delay
      localparam int L = STAGES - 2;
      logic [L-1:0] dv_q;
      logic [L-1:0] dr_q;

      // Stage 2 result followed by pure valid/data delay stages
      always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
          dv_q <= '0;
          dr_q <= '0;
        end else begin
          dv_q[0] <= s1_v_q;
          if (s1_v_q) dr_q[0] <= res2;
          for (int k = 1; k < L; k++) begin
            dv_q[k] <= dv_q[k-1];
            if (dv_q[k-1]) dr_q[k] <= dr_q[k-1];
          end
        end
      end

      assign load_v = dv_q[L-1];
      assign load_r = dr_q[L-1];
    end
  end

  // Output register: ZN only moves on valid slots, otherwise holds
  logic ov_q;
  logic zn_q;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      ov_q <= 1'b0;
      zn_q <= 1'b1;
    end else begin
      ov_q <= load_v;
      if (load_v) zn_q <= load_r;
    end
  end

  // Toggle detection against the value ZN holds before this load
  logic          toggle;
  logic          sat;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign toggle = load_v && (load_r != zn_q);
  assign sat    = &cnt_q;

  // Next counter value: clear beats increment, saturation blocks increment
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (toggle && !sat) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Toggle counter state
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign OUT_VALID  = ov_q;
  assign ZN         = zn_q;
  assign TOGGLE_CNT = cnt_q;
  assign CNT_SAT    = sat;

endmodule

// File: tb/tb_oai_gw_pipe.sv
// Bench for oai_gw_pipe: three instances (default, 4-bit counter, 4-stage)
// share one stimulus stream and are checked against a behavioural model.
module tb_oai_gw_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] mode;
  logic [5:0] a;
  logic       cnt_clr;

  logic [2:0]  ov;
  logic [2:0]  zn;
  logic [2:0]  sat;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [15:0] cnt2;
  logic [15:0] dcnt [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  oai_gw_pipe #(.G(3), .W(2), .STAGES(2), .CW(16)) u_dut0 (
    .CK(clk), .RST(rst), .IN_VALID(in_valid), .MODE(mode), .A(a), .CNT_CLR(cnt_clr),
    .OUT_VALID(ov[0]), .ZN(zn[0]), .TOGGLE_CNT(cnt0), .CNT_SAT(sat[0]));

  oai_gw_pipe #(.G(3), .W(2), .STAGES(2), .CW(4)) u_dut1 (
    .CK(clk), .RST(rst), .IN_VALID(in_valid), .MODE(mode), .A(a), .CNT_CLR(cnt_clr),
    .OUT_VALID(ov[1]), .ZN(zn[1]), .TOGGLE_CNT(cnt1), .CNT_SAT(sat[1]));

  oai_gw_pipe #(.G(3), .W(2), .STAGES(4), .CW(16)) u_dut2 (
    .CK(clk), .RST(rst), .IN_VALID(in_valid), .MODE(mode), .A(a), .CNT_CLR(cnt_clr),
    .OUT_VALID(ov[2]), .ZN(zn[2]), .TOGGLE_CNT(cnt2), .CNT_SAT(sat[2]));

  assign dcnt[0] = cnt0;
  assign dcnt[1] = {12'h000, cnt1};
  assign dcnt[2] = cnt2;

  // ---------------- reference model ----------------
  localparam int ST [3] = '{2, 2, 4};
  localparam int MX [3] = '{65535, 15, 65535};

  logic [3:0] hv [3];
  logic [3:0] hr [3];
  logic [2:0] m_ov;
  logic [2:0] m_zn;
  int         m_cnt [3];

  // Gate function from the rules: count groups that are non-zero / all-ones
  function automatic logic ref_zn(input logic [1:0] m, input logic [5:0] aa);
    int  n_nz;
    int  n_one;
    int  grp;
    logic val;
    n_nz  = 0;
    n_one = 0;
    for (int g = 0; g < 3; g++) begin
      grp = (int'(aa) >> (2 * g)) & 3;
      if (grp != 0) n_nz++;
      if (grp == 3) n_one++;
    end
    val = m[1] ? (n_one > 0) : (n_nz == 3);
    return m[0] ? val : !val;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [3:0] nv;
    logic [3:0] nr;
    logic       cr;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        hv[k]    <= 4'b0;
        hr[k]    <= 4'b0;
        m_ov[k]  <= 1'b0;
        m_zn[k]  <= 1'b1;
        m_cnt[k] <= 0;
      end
    end else begin
      cr = ref_zn(mode, a);
      for (int k = 0; k < 3; k++) begin
        nv = {hv[k][2:0], in_valid};
        nr = {hr[k][2:0], cr};
        hv[k]   <= nv;
        hr[k]   <= nr;
        m_ov[k] <= nv[ST[k]-1];
        if (nv[ST[k]-1]) m_zn[k] <= nr[ST[k]-1];
        if (cnt_clr)
          m_cnt[k] <= 0;
        else if (nv[ST[k]-1] && (nr[ST[k]-1] != m_zn[k]) && (m_cnt[k] < MX[k]))
          m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [1:0] m, input logic [5:0] aa, input logic clr);
    in_valid = v;
    mode     = m;
    a        = aa;
    cnt_clr  = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0; mode = 2'b00; a = 6'h00; cnt_clr = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (zn[k] !== 1'b1) begin n_bad++; $display("FAIL reset_zn dut%0d: got %b want 1", k, zn[k]); end
      n_cmp++;
      if (ov[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ov dut%0d: got %b want 0", k, ov[k]); end
      n_cmp++;
      if (dcnt[k] !== 16'd0) begin n_bad++; $display("FAIL reset_cnt dut%0d: got %0d want 0", k, dcnt[k]); end
      n_cmp++;
      if (sat[k] !== 1'b0) begin n_bad++; $display("FAIL reset_sat dut%0d: got %b want 0", k, sat[k]); end
    end
    $display("reset: zn=%b ov=%b sat=%b", zn, ov, sat);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_oai();
    do_reset();
    drive(1'b1, 2'b00, 6'b10_10_01, 1'b0);
    n_cmp++;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL oai_early_ov: got %b want 0", ov[0]); end
    drive(1'b0, 2'b00, 6'b00_00_00, 1'b0);
    n_cmp++;
    if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL oai1_ov: got %b want 1", ov[0]); end
    n_cmp++;
    if (zn[0] !== 1'b0) begin n_bad++; $display("FAIL oai1_zn: got %b want 0", zn[0]); end
    n_cmp++;
    if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL oai1_cnt: got %0d want 1", cnt0); end
    $display("oai #1: ov=%b zn=%b cnt=%0d", ov[0], zn[0], cnt0);
    drive(1'b1, 2'b00, 6'b00_10_01, 1'b0);
    drive(1'b0, 2'b00, 6'b00_00_00, 1'b0);
    n_cmp++;
    if (zn[0] !== 1'b1) begin n_bad++; $display("FAIL oai2_zn: got %b want 1", zn[0]); end
    n_cmp++;
    if (cnt0 !== 16'd2) begin n_bad++; $display("FAIL oai2_cnt: got %0d want 2", cnt0); end
    $display("oai #2: ov=%b zn=%b cnt=%0d", ov[0], zn[0], cnt0);
  endtask

  task automatic test_modes();
    logic [1:0] md [4];
    logic       ex [4];
    md = '{2'b10, 2'b11, 2'b00, 2'b01};
    ex = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, md[i], 6'b11_11_11, 1'b0);
      else       drive(1'b0, 2'b00, 6'b00_00_00, 1'b0);
      if (i >= 1) begin
        n_cmp++;
        if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL modes_ov[%0d]: got %b want 1", i-1, ov[0]); end
        n_cmp++;
        if (zn[0] !== ex[i-1]) begin n_bad++; $display("FAIL modes_zn[%0d]: got %b want %b", i-1, zn[0], ex[i-1]); end
        $display("mode %b: ov=%b zn=%b", md[i-1], ov[0], zn[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i < 8) drive(1'b1, 2'b00, (i % 2 == 0) ? 6'h3F : 6'h00, 1'b0);
      else       drive(1'b0, 2'b00, 6'h00, 1'b0);
      if (i >= 1 && i <= 8) begin
        n_cmp++;
        if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_ov[%0d]: got %b want 1", i, ov[0]); end
      end else if (i > 8) begin
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL idle_ov[%0d]: got %b want 0", i, ov[0]); end
        n_cmp++;
        if (zn[0] !== 1'b1) begin n_bad++; $display("FAIL idle_zn[%0d]: got %b want 1", i, zn[0]); end
      end
      $display("b2b cycle %0d: ov=%b zn=%b cnt=%0d", i, ov[0], zn[0], cnt0);
    end
    n_cmp++;
    if (cnt0 !== 16'd8) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 8", cnt0); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b00, (i % 2 == 0) ? 6'h3F : 6'h00, 1'b0);
    drive(1'b0, 2'b00, 6'h00, 1'b0);
    n_cmp++;
    if (cnt1 !== 4'd15) begin n_bad++; $display("FAIL sat_cnt: got %0d want 15", cnt1); end
    n_cmp++;
    if (sat[1] !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %b want 1", sat[1]); end
    n_cmp++;
    if (cnt0 !== 16'd20) begin n_bad++; $display("FAIL sat_wide_cnt: got %0d want 20", cnt0); end
    $display("saturate: cnt4=%0d sat=%b cnt16=%0d", cnt1, sat[1], cnt0);
    drive(1'b1, 2'b00, 6'h3F, 1'b0);
    drive(1'b0, 2'b00, 6'h00, 1'b1);
    cnt_clr = 1'b0;
    n_cmp++;
    if (zn[1] !== 1'b0) begin n_bad++; $display("FAIL clr_zn: got %b want 0", zn[1]); end
    n_cmp++;
    if (cnt1 !== 4'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d want 0", cnt1); end
    n_cmp++;
    if (sat[1] !== 1'b0) begin n_bad++; $display("FAIL clr_sat: got %b want 0", sat[1]); end
    $display("clear+toggle: zn=%b cnt4=%0d sat=%b", zn[1], cnt1, sat[1]);
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 6'h3F, 1'b0);
    n_cmp++;
    if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_ov: got %b want 0", ov[2]); end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b00, 6'h00, 1'b0);
      n_cmp++;
      if (ov[2] !== 1'b0) begin n_bad++; $display("FAIL midrst_ov[%0d]: got %b want 0", i, ov[2]); end
      n_cmp++;
      if (zn[2] !== 1'b1) begin n_bad++; $display("FAIL midrst_zn[%0d]: got %b want 1", i, zn[2]); end
      $display("midrst cycle %0d: ov=%b zn=%b", i, ov[2], zn[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 6'($urandom), $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (ov[k] !== m_ov[k]) begin n_bad++; $display("FAIL rnd_ov dut%0d cyc%0d: got %b want %b", k, i, ov[k], m_ov[k]); end
        n_cmp++;
        if (zn[k] !== m_zn[k]) begin n_bad++; $display("FAIL rnd_zn dut%0d cyc%0d: got %b want %b", k, i, zn[k], m_zn[k]); end
        n_cmp++;
        if (dcnt[k] !== 16'(m_cnt[k])) begin n_bad++; $display("FAIL rnd_cnt dut%0d cyc%0d: got %0d want %0d", k, i, dcnt[k], m_cnt[k]); end
        n_cmp++;
        if (sat[k] !== (m_cnt[k] == MX[k])) begin n_bad++; $display("FAIL rnd_sat dut%0d cyc%0d: got %b want %b", k, i, sat[k], m_cnt[k] == MX[k]); end
      end
      $display("rnd %0d: v=%b m=%b a=%b clr=%b ov=%b zn=%b cnt=%0d/%0d/%0d", i, in_valid, mode, a, cnt_clr, ov, zn, cnt0, cnt1, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_oai();
    test_modes();
    test_back_to_back();
    test_saturation();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
